// File: rtl/pipe_pkg.sv
// Payload types carried by the pipeline-register stages between core pipeline boundaries.
package pipe_pkg;

   typedef struct packed {
      logic [63:0] alu_result;
      logic [63:0] read_data;
      logic [4:0]  rd;
      logic [63:0] pc_plus4;
      logic        reg_write;
      logic [1:0]  result_src;
   } mw_payload_t;

   localparam int MW_PAYLOAD_W = $bits(mw_payload_t);

   // Entries one stage can hold: one main register per slot, plus one skid register when enabled.
   function automatic int stage_capacity(input int depth, input int skid);
      return depth * ((skid != 0) ? 2 : 1);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid/ready register slot, 1-cycle latency; SKID=1 adds a skid entry so up_rdy comes from a flop.
// rst or flush masks both handshakes in the cycle they are asserted.
module pipe_slot #(
   parameter int DATA_W = 8,
   parameter int SKID   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_vld,
   output logic              up_rdy,
   input  logic [DATA_W-1:0] up_dat,
   output logic              dn_vld,
   input  logic              dn_rdy,
   output logic [DATA_W-1:0] dn_dat,
   output logic [1:0]        occ
);

   logic              valid_q, valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              kill;
   logic              push;
   logic              pop;

   assign kill   = rst | flush;
   assign up_rdy = ~kill & ((SKID != 0) ? ~skid_valid_q : (~valid_q | dn_rdy));
   assign dn_vld = valid_q & ~kill;
   assign dn_dat = data_q;
   assign push   = up_vld & up_rdy;
   assign pop    = dn_vld & dn_rdy;
   assign occ    = {1'b0, valid_q} + {1'b0, skid_valid_q};

   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // up_rdy is low here, so the parked beat refills main before anything new is taken.
         if (pop) begin
            data_d       = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (push) begin
         if (SKID == 0 || !valid_q || pop) begin
            valid_d = 1'b1;
            data_d  = up_dat;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = up_dat;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// DEPTH chained pipe_slot registers carrying an opaque payload; latency DEPTH cycles, 1 beat/cycle.
// Backpressure ripples combinationally per slot when SKID=0, is cut by a registered ready when SKID=1.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W = MW_PAYLOAD_W,
   parameter int DEPTH  = 1,
   parameter int SKID   = 0,
   parameter int CNT_W  = $clog2(stage_capacity(DEPTH, SKID) + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  occupancy
);

   // Each slot owns its link signals so the ready chain never loops through one shared array.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic              up_vld;
      logic              up_rdy;
      logic [DATA_W-1:0] up_dat;
      logic              dn_vld;
      logic              dn_rdy;
      logic [DATA_W-1:0] dn_dat;
      logic [1:0]        slot_occ;
      logic [CNT_W-1:0]  occ_acc;

      if (i == 0) begin : g_head
         assign up_vld  = in_valid;
         assign up_dat  = in_data;
         assign occ_acc = CNT_W'(slot_occ);
      end else begin : g_link
         assign up_vld  = g_slot[i-1].dn_vld;
         assign up_dat  = g_slot[i-1].dn_dat;
         assign occ_acc = g_slot[i-1].occ_acc + CNT_W'(slot_occ);
      end

      if (i == DEPTH - 1) begin : g_tail
         assign dn_rdy = out_ready;
      end else begin : g_next
         assign dn_rdy = g_slot[i+1].up_rdy;
      end

      pipe_slot #(
         .DATA_W (DATA_W),
         .SKID   (SKID)
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .flush  (flush),
         .up_vld (up_vld),
         .up_rdy (up_rdy),
         .up_dat (up_dat),
         .dn_vld (dn_vld),
         .dn_rdy (dn_rdy),
         .dn_dat (dn_dat),
         .occ    (slot_occ)
      );
   end

   assign in_ready  = g_slot[0].up_rdy;
   assign out_valid = g_slot[DEPTH-1].dn_vld;
   assign out_data  = g_slot[DEPTH-1].dn_dat;
   assign occupancy = g_slot[DEPTH-1].occ_acc;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: seven configurations side by side, directed scenarios plus a queue-model random run.
module tb_pipe_stage_hs;

   localparam int DW = 16;
   localparam int NC = 7;

   // Instance table: 0 D1S0, 1 D1S1, 2 D4S0, 3 D4S1, 4 D2S0, 5 D2S1, 6 D3S1.
   function automatic int cfg_dep(input int i);
      case (i)
         0, 1:    return 1;
         2, 3:    return 4;
         4, 5:    return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int cfg_skid(input int i);
      return (i == 1 || i == 3 || i == 5 || i == 6) ? 1 : 0;
   endfunction

   logic          clk;
   logic          rst_v       [NC];
   logic          flush_v     [NC];
   logic          in_valid_v  [NC];
   logic          in_ready_v  [NC];
   logic [DW-1:0] in_data_v   [NC];
   logic          out_valid_v [NC];
   logic          out_ready_v [NC];
   logic [DW-1:0] out_data_v  [NC];
   logic [3:0]    occ_v       [NC];

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      localparam int D  = cfg_dep(g);
      localparam int S  = cfg_skid(g);
      localparam int CW = $clog2(D * (1 + S) + 1);
      logic [CW-1:0] occ_w;

      pipe_stage_hs #(.DATA_W(DW), .DEPTH(D), .SKID(S)) u_dut (
         .clk       (clk),
         .rst       (rst_v[g]),
         .flush     (flush_v[g]),
         .in_valid  (in_valid_v[g]),
         .in_ready  (in_ready_v[g]),
         .in_data   (in_data_v[g]),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready_v[g]),
         .out_data  (out_data_v[g]),
         .occupancy (occ_w)
      );
      assign occ_v[g] = 4'(occ_w);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input int c, input logic v, input logic [DW-1:0] d, input logic r);
      in_valid_v[c]  = v;
      in_data_v[c]   = d;
      out_ready_v[c] = r;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < NC; c++) rst_v[c] = 1'b0;
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
         checks++;
         if (in_ready_v[c] !== 1'b1) begin failures++; $display("FAIL reset_in_ready inst=%0d got=%b exp=1", c, in_ready_v[c]); end
         checks++;
         if (out_valid_v[c] !== 1'b0) begin failures++; $display("FAIL reset_out_valid inst=%0d got=%b exp=0", c, out_valid_v[c]); end
         checks++;
         if (out_data_v[c] !== '0) begin failures++; $display("FAIL reset_out_data inst=%0d got=%h exp=0", c, out_data_v[c]); end
         checks++;
         if (occ_v[c] !== 4'd0) begin failures++; $display("FAIL reset_occupancy inst=%0d got=%0d exp=0", c, occ_v[c]); end
      end
      next_cycle();
   endtask

   task automatic test_depth1();
      logic [DW-1:0] vals [4];
      vals = '{16'h00A5, 16'h005A, 16'h003C, 16'h0000};
      for (int k = 0; k < 4; k++) begin
         drive(0, (k < 3), vals[k], 1'b1);
         @(negedge clk);
         checks++;
         if (in_ready_v[0] !== 1'b1) begin failures++; $display("FAIL d1_in_ready k=%0d got=%b exp=1", k, in_ready_v[0]); end
         if (k > 0) begin
            checks++;
            if (out_valid_v[0] !== 1'b1) begin failures++; $display("FAIL d1_out_valid k=%0d got=%b exp=1", k, out_valid_v[0]); end
            checks++;
            if (out_data_v[0] !== vals[k-1]) begin failures++; $display("FAIL d1_out_data k=%0d got=%h exp=%h", k, out_data_v[0], vals[k-1]); end
            checks++;
            if (occ_v[0] !== 4'd1) begin failures++; $display("FAIL d1_occupancy k=%0d got=%0d exp=1", k, occ_v[0]); end
         end
         next_cycle();
      end
      drive(0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid_v[0] !== 1'b0 || occ_v[0] !== 4'd0) begin
         failures++; $display("FAIL d1_drain got valid=%b occ=%0d exp valid=0 occ=0", out_valid_v[0], occ_v[0]);
      end
      next_cycle();
   endtask

   task automatic test_skid_order();
      int sent = 1;
      int rcvd = 0;
      int peak = 0;
      int t    = 0;
      logic r;
      for (int k = 0; k < 12; k++) begin
         drive(6, (sent <= 10), 16'(sent), 1'b0);
         @(negedge clk);
         if (int'(occ_v[6]) > peak) peak = int'(occ_v[6]);
         if (in_valid_v[6] && in_ready_v[6]) sent++;
         next_cycle();
      end
      drive(6, 1'b1, 16'(sent), 1'b0);
      @(negedge clk);
      checks++;
      if (peak != 6 || occ_v[6] !== 4'd6) begin failures++; $display("FAIL skid_peak got peak=%0d occ=%0d exp=6", peak, occ_v[6]); end
      checks++;
      if (in_ready_v[6] !== 1'b0) begin failures++; $display("FAIL skid_full_in_ready got=%b exp=0", in_ready_v[6]); end
      out_ready_v[6] = 1'b1;
      #1;
      checks++;
      if (in_ready_v[6] !== 1'b0) begin failures++; $display("FAIL skid_ready_registered got=%b exp=0", in_ready_v[6]); end
      checks++;
      if (out_valid_v[6] !== 1'b1 || out_data_v[6] !== 16'(rcvd + 1)) begin
         failures++; $display("FAIL skid_head got valid=%b data=%h exp valid=1 data=%h", out_valid_v[6], out_data_v[6], 16'(rcvd + 1));
      end
      rcvd++;
      next_cycle();
      while (rcvd < 10 && t < 300) begin
         r = ((t % 3) == 0);
         drive(6, (sent <= 10), 16'(sent), r);
         @(negedge clk);
         if (out_valid_v[6] && r) begin
            checks++;
            if (out_data_v[6] !== 16'(rcvd + 1)) begin failures++; $display("FAIL skid_order got=%h exp=%h", out_data_v[6], 16'(rcvd + 1)); end
            rcvd++;
         end
         if (in_valid_v[6] && in_ready_v[6]) sent++;
         checks++;
         if (occ_v[6] > 4'd6) begin failures++; $display("FAIL skid_occ_bound got=%0d exp<=6", occ_v[6]); end
         next_cycle();
         t++;
      end
      checks++;
      if (rcvd != 10) begin failures++; $display("FAIL skid_timeout got rcvd=%0d exp=10", rcvd); end
      drive(6, 1'b0, '0, 1'b0);
   endtask

   task automatic test_full_skid0();
      int src = 1;
      int expd = 1;
      for (int k = 0; k < 4; k++) begin
         drive(4, 1'b1, 16'(src), 1'b0);
         @(negedge clk);
         if (in_ready_v[4]) src++;
         next_cycle();
      end
      drive(4, 1'b1, 16'(src), 1'b0);
      @(negedge clk);
      checks++;
      if (src != 3) begin failures++; $display("FAIL full_accepted got=%0d exp=2", src - 1); end
      checks++;
      if (in_ready_v[4] !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready_v[4]); end
      checks++;
      if (occ_v[4] !== 4'd2) begin failures++; $display("FAIL full_occupancy got=%0d exp=2", occ_v[4]); end
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(4, 1'b1, 16'(src), 1'b1);
         @(negedge clk);
         checks++;
         if (in_ready_v[4] !== 1'b1) begin failures++; $display("FAIL full_pushpop_ready k=%0d got=%b exp=1", k, in_ready_v[4]); end
         checks++;
         if (out_valid_v[4] !== 1'b1 || out_data_v[4] !== 16'(expd)) begin
            failures++; $display("FAIL full_pushpop_data k=%0d got valid=%b data=%h exp data=%h", k, out_valid_v[4], out_data_v[4], 16'(expd));
         end
         checks++;
         if (occ_v[4] !== 4'd2) begin failures++; $display("FAIL full_pushpop_occ k=%0d got=%0d exp=2", k, occ_v[4]); end
         expd++;
         if (in_ready_v[4]) src++;
         next_cycle();
      end
      drive(4, 1'b0, '0, 1'b0);
   endtask

   task automatic test_rst_mid();
      int t = 0;
      drive(4, 1'b1, 16'h0077, 1'b0);
      @(negedge clk);
      while (occ_v[4] !== 4'd2 && t < 10) begin
         next_cycle();
         @(negedge clk);
         t++;
      end
      checks++;
      if (occ_v[4] !== 4'd2) begin failures++; $display("FAIL rst_prefill got=%0d exp=2", occ_v[4]); end
      next_cycle();
      rst_v[4] = 1'b1;
      drive(4, 1'b1, 16'h0088, 1'b1);
      @(negedge clk);
      checks++;
      if (in_ready_v[4] !== 1'b0 || out_valid_v[4] !== 1'b0) begin
         failures++; $display("FAIL rst_during got ready=%b valid=%b exp 0 0", in_ready_v[4], out_valid_v[4]);
      end
      next_cycle();
      rst_v[4] = 1'b0;
      drive(4, 1'b0, '0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid_v[4] !== 1'b0) begin failures++; $display("FAIL rst_after_valid got=%b exp=0", out_valid_v[4]); end
      checks++;
      if (out_data_v[4] !== '0) begin failures++; $display("FAIL rst_after_data got=%h exp=0", out_data_v[4]); end
      checks++;
      if (occ_v[4] !== 4'd0) begin failures++; $display("FAIL rst_after_occ got=%0d exp=0", occ_v[4]); end
      checks++;
      if (in_ready_v[4] !== 1'b1) begin failures++; $display("FAIL rst_after_ready got=%b exp=1", in_ready_v[4]); end
      next_cycle();
   endtask

   task automatic test_flush();
      int src  = 1;
      int sent = 0;
      int nout = 0;
      for (int k = 0; k < 10; k++) begin
         drive(5, 1'b1, 16'h0100 + 16'(src), 1'b0);
         @(negedge clk);
         if (in_ready_v[5]) src++;
         next_cycle();
      end
      drive(5, 1'b1, 16'h0100 + 16'(src), 1'b0);
      @(negedge clk);
      checks++;
      if (occ_v[5] !== 4'd4 || in_ready_v[5] !== 1'b0) begin
         failures++; $display("FAIL flush_prefill got occ=%0d ready=%b exp occ=4 ready=0", occ_v[5], in_ready_v[5]);
      end
      next_cycle();
      flush_v[5] = 1'b1;
      drive(5, 1'b1, 16'hDEAD, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid_v[5] !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid_v[5]); end
      checks++;
      if (in_ready_v[5] !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready_v[5]); end
      next_cycle();
      flush_v[5] = 1'b0;
      drive(5, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (occ_v[5] !== 4'd0 || out_valid_v[5] !== 1'b0) begin
         failures++; $display("FAIL flush_after got occ=%0d valid=%b exp occ=0 valid=0", occ_v[5], out_valid_v[5]);
      end
      next_cycle();
      for (int k = 0; k < 8; k++) begin
         drive(5, (sent < 2), 16'(16'h0101 * (sent + 1)), 1'b1);
         @(negedge clk);
         if (out_valid_v[5]) begin
            checks++;
            if (nout >= 2 || out_data_v[5] !== 16'(16'h0101 * (nout + 1))) begin
               failures++; $display("FAIL flush_post_data n=%0d got=%h exp=%h", nout, out_data_v[5], 16'(16'h0101 * (nout + 1)));
            end
            nout++;
         end
         if (in_valid_v[5] && in_ready_v[5]) sent++;
         next_cycle();
      end
      checks++;
      if (nout != 2) begin failures++; $display("FAIL flush_post_count got=%0d exp=2", nout); end
      drive(5, 1'b0, '0, 1'b0);
   endtask

   task automatic test_random(input int c);
      logic [DW-1:0] q [$];
      int   cap = cfg_dep(c) * (1 + cfg_skid(c));
      logic v, r, fl, ir, ov;
      logic [DW-1:0] d;
      rst_v[c] = 1'b1;
      drive(c, 1'b0, '0, 1'b0);
      next_cycle();
      rst_v[c] = 1'b0;
      v = 1'($urandom_range(0, 1));
      d = DW'($urandom);
      for (int t = 0; t < 1000; t++) begin
         fl = ($urandom_range(0, 63) == 0);
         r  = 1'($urandom_range(0, 1));
         flush_v[c] = fl;
         drive(c, v, d, r);
         @(negedge clk);
         ir = in_ready_v[c];
         ov = out_valid_v[c];
         checks++;
         if (occ_v[c] !== 4'(q.size())) begin failures++; $display("FAIL rnd_occ inst=%0d t=%0d got=%0d exp=%0d", c, t, occ_v[c], q.size()); end
         if (fl) begin
            checks++;
            if (ov !== 1'b0 || ir !== 1'b0) begin failures++; $display("FAIL rnd_flush inst=%0d t=%0d got valid=%b ready=%b exp 0 0", c, t, ov, ir); end
            q.delete();
         end else begin
            if (q.size() == 0) begin
               checks++;
               if (ov !== 1'b0 || ir !== 1'b1) begin failures++; $display("FAIL rnd_empty inst=%0d t=%0d got valid=%b ready=%b exp 0 1", c, t, ov, ir); end
            end else if (cfg_dep(c) == 1) begin
               checks++;
               if (ov !== 1'b1) begin failures++; $display("FAIL rnd_d1_valid inst=%0d t=%0d got=%b exp=1", c, t, ov); end
            end
            if (q.size() == cap) begin
               checks++;
               if (ir !== ((cfg_skid(c) != 0) ? 1'b0 : r)) begin failures++; $display("FAIL rnd_full_ready inst=%0d t=%0d got=%b out_ready=%b", c, t, ir, r); end
            end
            if (ov === 1'b1 && r) begin
               checks++;
               if (q.size() == 0) begin
                  failures++; $display("FAIL rnd_spurious inst=%0d t=%0d got data=%h exp no entry", c, t, out_data_v[c]);
               end else begin
                  if (out_data_v[c] !== q[0]) begin failures++; $display("FAIL rnd_data inst=%0d t=%0d got=%h exp=%h", c, t, out_data_v[c], q[0]); end
                  void'(q.pop_front());
               end
            end
            if (v && ir === 1'b1) q.push_back(d);
         end
         if (fl || !v || ir === 1'b1) begin
            v = 1'($urandom_range(0, 1));
            d = DW'($urandom);
         end
         next_cycle();
      end
      flush_v[c] = 1'b0;
      drive(c, 1'b0, '0, 1'b0);
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin
         rst_v[c]   = 1'b1;
         flush_v[c] = 1'b0;
         drive(c, 1'b0, '0, 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_depth1();
      test_skid_order();
      test_full_skid0();
      test_rst_mid();
      test_flush();
      for (int c = 0; c < 4; c++) test_random(c);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
